// File: rtl/seg_scan_ctrl_if.sv
// Display-update handshake bundle: one hex nibble per digit offered with valid/ready.
interface seg_scan_ctrl_if #(parameter int NDIG = 4);
  logic              upd_valid;
  logic [4*NDIG-1:0] upd_data;
  logic              upd_ready;

  modport master (output upd_valid, output upd_data, input upd_ready);
  modport slave  (input upd_valid, input upd_data, output upd_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with PWM dimming and frame-aligned data updates.
// Optional leading-zero blanking when BLANK_LEAD_EN is defined.
//
// pend_state | meaning
// PEND_EMPTY | no update waiting, upd_ready high
// PEND_FULL  | update held in pending, applied at the next frame boundary
module seg_scan_ctrl #(
  parameter int NDIG  = 4,
  parameter int DWELL = 15000,
  parameter int CBITS = 14
) (
  input  logic               clk,
  input  logic               rst,
  seg_scan_ctrl_if.slave     upd,
  input  logic [2:0]         bright,
  output logic [6:0]         segment,
  output logic [NDIG-1:0]    digit_en,
  output logic               frame_tick
);

  localparam int IBITS = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int PW    = CBITS + 4;
  localparam logic [CBITS-1:0] LAST_CNT = CBITS'(DWELL - 1);
  localparam logic [IBITS-1:0] LAST_IDX = IBITS'(NDIG - 1);
  localparam logic [PW-1:0]    DWELL_W  = PW'(DWELL);
  localparam logic [NDIG-1:0]  ONE      = NDIG'(1);

  typedef enum logic {PEND_EMPTY = 1'b0, PEND_FULL = 1'b1} pend_t;

  pend_t             pend_state;
  logic [CBITS-1:0]  cnt;
  logic [IBITS-1:0]  idx;
  logic [4*NDIG-1:0] shadow;
  logic [4*NDIG-1:0] pending;
  logic              wrap;
  logic              boundary;
  logic              pwm_on;
  logic [PW-1:0]     cnt_x8;
  logic [PW-1:0]     thresh;
  logic [3:0]        nib;
  logic [6:0]        seg_dec;
  logic [NDIG-1:0]   blank;

  assign upd.upd_ready = (pend_state == PEND_EMPTY);
  assign wrap          = (cnt == LAST_CNT);
  assign boundary      = wrap && (idx == LAST_IDX);

  // Both sides fit in CBITS+4 bits, so the compare never truncates.
  assign cnt_x8 = {4'b0000, cnt} << 3;
  assign thresh = ({{(PW-3){1'b0}}, bright} + PW'(1)) * DWELL_W;
  assign pwm_on = (cnt_x8 < thresh);

  assign nib = shadow[{idx, 2'b00} +: 4];

  always_comb begin
    seg_dec = 7'h00;
    case (nib)
      4'h0: seg_dec = 7'h3F;
      4'h1: seg_dec = 7'h06;
      4'h2: seg_dec = 7'h5B;
      4'h3: seg_dec = 7'h4F;
      4'h4: seg_dec = 7'h66;
      4'h5: seg_dec = 7'h6D;
      4'h6: seg_dec = 7'h7D;
      4'h7: seg_dec = 7'h07;
      4'h8: seg_dec = 7'h7F;
      4'h9: seg_dec = 7'h6F;
      4'hA: seg_dec = 7'h77;
      4'hB: seg_dec = 7'h7C;
      4'hC: seg_dec = 7'h39;
      4'hD: seg_dec = 7'h5E;
      4'hE: seg_dec = 7'h79;
      4'hF: seg_dec = 7'h71;
      default: seg_dec = 7'h00;
    endcase
  end

`ifdef BLANK_LEAD_EN
  logic zeros_above;
  // Walk down from the top digit; digit 0 is never blanked.
  always_comb begin
    blank       = '0;
    zeros_above = 1'b1;
    for (int k = NDIG - 1; k > 0; k--) begin
      zeros_above = zeros_above && (shadow[4*k +: 4] == 4'h0);
      blank[k]    = zeros_above;
    end
  end
`else
  assign blank = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      shadow     <= '0;
      pending    <= '0;
      pend_state <= PEND_EMPTY;
      segment    <= '0;
      digit_en   <= '0;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= wrap ? '0 : cnt + CBITS'(1);
      frame_tick <= boundary;
      if (wrap)
        idx <= (idx == LAST_IDX) ? '0 : idx + IBITS'(1);

      if (pwm_on) begin
        digit_en <= ONE << idx;
        segment  <= blank[idx] ? 7'h00 : seg_dec;
      end else begin
        digit_en <= '0;
        segment  <= 7'h00;
      end

      // A transfer landing on a boundary stays pending until the next one.
      case (pend_state)
        PEND_EMPTY: begin
          if (upd.upd_valid) begin
            pending    <= upd.upd_data;
            pend_state <= PEND_FULL;
          end
        end
        PEND_FULL: begin
          if (boundary) begin
            shadow     <= pending;
            pending    <= '0;
            pend_state <= PEND_EMPTY;
          end
        end
        default: pend_state <= PEND_EMPTY;
      endcase
    end
  end

endmodule
